// File: rtl/rvfpm_pkg.sv
// Shared definitions for the rvfpm offload path.
// Holds the RISC-V opcode constants the XIF classifier recognises, the
// single-precision format/width encodings, and the issue-queue entry record.
package rvfpm_pkg;

  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;

  localparam logic [1:0] FMT_S    = 2'b00;
  localparam logic [2:0] W_FUNCT3 = 3'b010;

  // Widest XIF id an entry can hold; narrower ids are zero-extended on store.
  localparam int XIF_ID_MAX = 16;

  typedef struct packed {
    logic [31:0]           instr;
    logic [XIF_ID_MAX-1:0] id;
    logic [31:0]           rs0;
    logic                  committed;
    logic                  killed;
  } issue_entry_t;

endpackage

// File: rtl/rvfpm_xif_decode.sv
// Combinational classifier: decides whether an instruction word is a
// single-precision FP instruction the rvfpm core executes.
// Ports:
//   instr  - 32-bit instruction word
//   accept - 1 when the word is OP-FP/FMA with fmt=S, or FLW/FSW
module rvfpm_xif_decode
  import rvfpm_pkg::*;
(
  input  logic [31:0] instr,
  output logic        accept
);

  logic [6:0] opcode;
  logic [1:0] fmt;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign fmt    = instr[26:25];
  assign funct3 = instr[14:12];

  // Fields not involved in classification.
  assign unused_bits = ^{instr[31:27], instr[24:15], instr[11:7]};

  always_comb begin
    accept = 1'b0;
    case (opcode)
      OPC_OP_FP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD:
        accept = (fmt == FMT_S);
      OPC_LOAD_FP, OPC_STORE_FP:
        accept = (funct3 == W_FUNCT3);
      default:
        accept = 1'b0;
    endcase
  end

endmodule

// File: rtl/rvfpm_xif_issue_queue.sv
// In-order issue queue between the CORE-V-XIF issue/commit interface and the
// rvfpm FPU. Accepted FP instructions are buffered with id and rs0; each entry
// is resolved by a commit or kill and committed entries leave in order.
// Ports:
//   ck, rst          - clock, synchronous active-low reset
//   issue_*          - XIF issue request; issue_accept is combinational
//   commit_*         - XIF commit/kill event, matched by id (oldest first)
//   fpu_valid/ready  - handshake toward the FPU, head contents on fpu_*
//   count            - number of occupied entries
module rvfpm_xif_issue_queue
  import rvfpm_pkg::*;
#(
  parameter int X_ID_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [31:0]                  issue_instr,
  input  logic [X_ID_WIDTH-1:0]        issue_id,
  input  logic [31:0]                  issue_rs0,
  output logic                         issue_accept,
  input  logic                         commit_valid,
  input  logic [X_ID_WIDTH-1:0]        commit_id,
  input  logic                         commit_kill,
  output logic                         fpu_valid,
  input  logic                         fpu_ready,
  output logic [31:0]                  fpu_instr,
  output logic [X_ID_WIDTH-1:0]        fpu_id,
  output logic [31:0]                  fpu_rs0,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  issue_entry_t           mem_reg [DEPTH];
  logic [DEPTH-1:0]       valid_reg;
  logic [PTR_W-1:0]       head_reg;
  logic [PTR_W-1:0]       tail_reg;
  logic [CNT_W-1:0]       count_reg;

  issue_entry_t           head_entry;
  logic                   head_valid;
  logic                   push;
  logic                   pop;
  logic [XIF_ID_MAX-1:0]  commit_id_ext;
  logic [DEPTH-1:0]       match;
  logic                   hit;
  logic [PTR_W-1:0]       hit_idx;
  logic [PTR_W-1:0]       scan_idx;
  logic                   commit_hit;
  logic                   bypass;

  rvfpm_xif_decode u_decode (
    .instr  (issue_instr),
    .accept (issue_accept)
  );

  assign head_entry  = mem_reg[head_reg];
  assign head_valid  = valid_reg[head_reg];
  assign fpu_valid   = head_valid & head_entry.committed & ~head_entry.killed;
  assign fpu_instr   = head_entry.instr;
  assign fpu_id      = head_entry.id[X_ID_WIDTH-1:0];
  assign fpu_rs0     = head_entry.rs0;
  assign count       = count_reg;

  assign issue_ready = (count_reg != CNT_W'(DEPTH));
  assign push        = issue_valid & issue_ready & issue_accept;
  // Killed heads drain without a handshake; committed heads wait for the FPU.
  assign pop         = head_valid & (head_entry.killed | (fpu_valid & fpu_ready));

  assign commit_id_ext = XIF_ID_MAX'(commit_id);

  // An entry is a commit candidate while it is live and still unresolved.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] & ~mem_reg[gi].committed &
                         ~mem_reg[gi].killed & (mem_reg[gi].id == commit_id_ext);
    end
  endgenerate

  // Scan from the head so that a reused id resolves the oldest instance.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_reg + PTR_W'(k);
      if (!hit && match[scan_idx]) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign commit_hit = commit_valid & hit;
  // Commit arriving together with its own issue resolves the new entry.
  assign bypass     = commit_valid & ~hit & push & (commit_id == issue_id);

  always_ff @(posedge ck) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_reg[k] <= '0;
      end
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      // The matched slot is live, so it can never be the tail slot being
      // written, and the popped head is already resolved, so it never matches.
      if (commit_hit) begin
        if (commit_kill) begin
          mem_reg[hit_idx].killed <= 1'b1;
        end else begin
          mem_reg[hit_idx].committed <= 1'b1;
        end
      end
      if (push) begin
        mem_reg[tail_reg] <= '{instr:     issue_instr,
                               id:        XIF_ID_MAX'(issue_id),
                               rs0:       issue_rs0,
                               committed: bypass & ~commit_kill,
                               killed:    bypass & commit_kill};
        valid_reg[tail_reg] <= 1'b1;
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg <= head_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfpm_xif_issue_queue.sv
// Directed, table-driven bench for rvfpm_xif_issue_queue.
module tb_rvfpm_xif_issue_queue;

  localparam logic [31:0] FADD   = 32'h00208053;
  localparam logic [31:0] ADD    = 32'h00000033;
  localparam logic [31:0] FADDD  = 32'h02208053;
  localparam logic [31:0] FLD    = 32'h00013087;
  localparam logic [31:0] FLW    = 32'h00012087;
  localparam logic [31:0] FMADDD = 32'h02000043;
  localparam logic [31:0] FMADDS = 32'h00000043;
  localparam logic [31:0] FSW    = 32'h00002027;

  logic        ck = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [31:0] issue_rs0;
  logic        issue_accept;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [31:0] fpu_instr;
  logic [3:0]  fpu_id;
  logic [31:0] fpu_rs0;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  rvfpm_xif_issue_queue #(.X_ID_WIDTH(4), .DEPTH(4)) dut (
    .ck           (ck),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_instr  (issue_instr),
    .issue_id     (issue_id),
    .issue_rs0    (issue_rs0),
    .issue_accept (issue_accept),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_kill  (commit_kill),
    .fpu_valid    (fpu_valid),
    .fpu_ready    (fpu_ready),
    .fpu_instr    (fpu_instr),
    .fpu_id       (fpu_id),
    .fpu_rs0      (fpu_rs0),
    .count        (count)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] instr;
    logic [3:0]  id;
    logic        cv;
    logic [3:0]  cid;
    logic        kill;
    logic        rdy;
    logic        acc;
    logic [2:0]  cnt;
    logic        fv;
    logic [3:0]  fid;
    logic [31:0] finstr;
    logic        ir;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic r, logic iv, logic [31:0] instr, logic [3:0] id,
                             logic cv, logic [3:0] cid, logic kill, logic rdy,
                             logic acc, logic [2:0] cnt, logic fv, logic [3:0] fid,
                             logic [31:0] finstr, logic ir);
    vec_t t;
    t.rst = r;  t.iv = iv;   t.instr = instr; t.id = id;
    t.cv = cv;  t.cid = cid; t.kill = kill;   t.rdy = rdy;
    t.acc = acc; t.cnt = cnt; t.fv = fv; t.fid = fid; t.finstr = finstr; t.ir = ir;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0; issue_instr = '0; issue_id = '0; issue_rs0 = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; fpu_ready = 1'b0;
  endtask

  initial begin
    //        rst iv instr   id  cv cid k rdy | acc cnt fv fid finstr ir
    tv.push_back(v(0,0,32'h0 ,0 ,0,0 ,0,0 , 0,0,0,0 ,32'h0,1)); // 0 reset
    tv.push_back(v(1,1,FADD  ,3 ,1,3 ,0,0 , 1,1,1,3 ,FADD ,1)); // 1 issue+commit
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,0,0,0 ,32'h0,1)); // 2 pop
    tv.push_back(v(1,1,ADD   ,1 ,0,0 ,0,0 , 0,0,0,0 ,32'h0,1)); // 3 integer
    tv.push_back(v(1,1,FADDD ,1 ,0,0 ,0,0 , 0,0,0,0 ,32'h0,1)); // 4 double
    tv.push_back(v(1,1,FLD   ,1 ,0,0 ,0,0 , 0,0,0,0 ,32'h0,1)); // 5 fld
    tv.push_back(v(1,1,FMADDD,1 ,0,0 ,0,0 , 0,0,0,0 ,32'h0,1)); // 6 fmadd.d
    tv.push_back(v(1,1,FMADDS,9 ,0,0 ,0,0 , 1,1,0,0 ,32'h0,1)); // 7 fmadd.s
    tv.push_back(v(1,0,32'h0 ,0 ,1,9 ,1,0 , 0,1,0,0 ,32'h0,1)); // 8 kill 9
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,0 , 0,0,0,0 ,32'h0,1)); // 9 drain kill
    tv.push_back(v(1,1,FADD  ,1 ,0,0 ,0,0 , 1,1,0,0 ,32'h0,1)); // 10
    tv.push_back(v(1,1,FADD  ,2 ,0,0 ,0,0 , 1,2,0,0 ,32'h0,1)); // 11
    tv.push_back(v(1,1,FADD  ,3 ,0,0 ,0,0 , 1,3,0,0 ,32'h0,1)); // 12
    tv.push_back(v(1,1,FSW   ,4 ,0,0 ,0,0 , 1,4,0,0 ,32'h0,0)); // 13 full
    tv.push_back(v(1,1,FADD  ,5 ,1,1 ,0,0 , 1,4,1,1 ,FADD ,0)); // 14 refused
    tv.push_back(v(1,0,32'h0 ,0 ,1,2 ,0,0 , 0,4,1,1 ,FADD ,0)); // 15
    tv.push_back(v(1,0,32'h0 ,0 ,1,3 ,0,0 , 0,4,1,1 ,FADD ,0)); // 16
    tv.push_back(v(1,0,32'h0 ,0 ,1,4 ,0,0 , 0,4,1,1 ,FADD ,0)); // 17
    tv.push_back(v(1,1,FADD  ,5 ,0,0 ,0,1 , 1,3,1,2 ,FADD ,1)); // 18 pop, not taken
    tv.push_back(v(1,1,FADD  ,5 ,1,5 ,0,1 , 1,3,1,3 ,FADD ,1)); // 19 push+pop, bypass
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,2,1,4 ,FSW  ,1)); // 20
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,1,1,5 ,FADD ,1)); // 21 wrapped
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,0,0,0 ,32'h0,1)); // 22
    tv.push_back(v(1,1,FADD  ,5 ,0,0 ,0,0 , 1,1,0,0 ,32'h0,1)); // 23
    tv.push_back(v(1,1,FADD  ,6 ,0,0 ,0,0 , 1,2,0,0 ,32'h0,1)); // 24
    tv.push_back(v(1,1,FADD  ,7 ,1,6 ,1,0 , 1,3,0,0 ,32'h0,1)); // 25 kill 6
    tv.push_back(v(1,0,32'h0 ,0 ,1,5 ,0,0 , 0,3,1,5 ,FADD ,1)); // 26
    tv.push_back(v(1,0,32'h0 ,0 ,1,7 ,0,0 , 0,3,1,5 ,FADD ,1)); // 27 hold
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,2,0,0 ,32'h0,1)); // 28 pop 5
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,1,1,7 ,FADD ,1)); // 29 drain 6
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,0,0,0 ,32'h0,1)); // 30 pop 7
    tv.push_back(v(1,1,FADD  ,2 ,0,0 ,0,0 , 1,1,0,0 ,32'h0,1)); // 31
    tv.push_back(v(1,1,FADD  ,3 ,1,3 ,0,0 , 1,2,0,0 ,32'h0,1)); // 32
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,2,0,0 ,32'h0,1)); // 33 stall
    tv.push_back(v(1,0,32'h0 ,0 ,1,2 ,0,1 , 0,2,1,2 ,FADD ,1)); // 34
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,1,1,3 ,FADD ,1)); // 35
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,0,0,0 ,32'h0,1)); // 36
    tv.push_back(v(1,1,FADD  ,8 ,0,0 ,0,0 , 1,1,0,0 ,32'h0,1)); // 37 dup id
    tv.push_back(v(1,1,FADD  ,8 ,0,0 ,0,0 , 1,2,0,0 ,32'h0,1)); // 38
    tv.push_back(v(1,0,32'h0 ,0 ,1,8 ,0,0 , 0,2,1,8 ,FADD ,1)); // 39 oldest
    tv.push_back(v(1,0,32'h0 ,0 ,1,8 ,1,1 , 0,1,0,0 ,32'h0,1)); // 40 kill younger
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,0,0,0 ,32'h0,1)); // 41
    tv.push_back(v(1,1,FADD  ,10,0,0 ,0,0 , 1,1,0,0 ,32'h0,1)); // 42
    tv.push_back(v(1,0,32'h0 ,0 ,1,11,0,0 , 0,1,0,0 ,32'h0,1)); // 43 unknown id
    tv.push_back(v(1,0,32'h0 ,0 ,1,10,0,0 , 0,1,1,10,FADD ,1)); // 44
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,0,0,0 ,32'h0,1)); // 45
    tv.push_back(v(1,1,FADD  ,1 ,1,1 ,0,0 , 1,1,1,1 ,FADD ,1)); // 46
    tv.push_back(v(1,1,FADD  ,2 ,1,2 ,0,0 , 1,2,1,1 ,FADD ,1)); // 47
    tv.push_back(v(1,1,FADD  ,3 ,1,3 ,0,0 , 1,3,1,1 ,FADD ,1)); // 48
    tv.push_back(v(0,0,32'h0 ,0 ,0,0 ,0,1 , 0,0,0,0 ,32'h0,1)); // 49 mid reset
    tv.push_back(v(1,0,32'h0 ,0 ,1,1 ,0,0 , 0,0,0,0 ,32'h0,1)); // 50 stale id
    tv.push_back(v(1,0,32'h0 ,0 ,1,2 ,0,0 , 0,0,0,0 ,32'h0,1)); // 51
    tv.push_back(v(1,1,FADD  ,1 ,0,0 ,0,0 , 1,1,0,0 ,32'h0,1)); // 52
    tv.push_back(v(1,0,32'h0 ,0 ,1,2 ,0,0 , 0,1,0,0 ,32'h0,1)); // 53 stale id
    tv.push_back(v(1,0,32'h0 ,0 ,1,1 ,0,0 , 0,1,1,1 ,FADD ,1)); // 54
    tv.push_back(v(1,0,32'h0 ,0 ,0,0 ,0,1 , 0,0,0,0 ,32'h0,1)); // 55

    rst = 1'b0;
    drive_idle();
    @(negedge ck);

    for (int i = 0; i < tv.size(); i++) begin
      rst          = tv[i].rst;
      issue_valid  = tv[i].iv;
      issue_instr  = tv[i].instr;
      issue_id     = tv[i].id;
      issue_rs0    = 32'hA500_0000 | 32'(tv[i].id);
      commit_valid = tv[i].cv;
      commit_id    = tv[i].cid;
      commit_kill  = tv[i].kill;
      fpu_ready    = tv[i].rdy;
      #1;
      check($sformatf("v%0d accept", i), 32'(issue_accept), 32'(tv[i].acc));
      @(posedge ck);
      #1;
      $display("vec %0d: instr=%h id=%0d cv=%0b cid=%0d kill=%0b rdy=%0b -> count=%0d fpu_valid=%0b fpu_id=%0d issue_ready=%0b",
               i, tv[i].instr, tv[i].id, tv[i].cv, tv[i].cid, tv[i].kill, tv[i].rdy,
               count, fpu_valid, fpu_id, issue_ready);
      check($sformatf("v%0d count", i), 32'(count), 32'(tv[i].cnt));
      check($sformatf("v%0d fpu_valid", i), 32'(fpu_valid), 32'(tv[i].fv));
      check($sformatf("v%0d issue_ready", i), 32'(issue_ready), 32'(tv[i].ir));
      if (tv[i].fv || !tv[i].rst) begin
        check($sformatf("v%0d fpu_id", i), 32'(fpu_id), 32'(tv[i].fid));
        check($sformatf("v%0d fpu_instr", i), fpu_instr, tv[i].finstr);
        check($sformatf("v%0d fpu_rs0", i), fpu_rs0,
              tv[i].fv ? (32'hA500_0000 | 32'(tv[i].fid)) : 32'h0);
      end
      @(negedge ck);
    end

    // FLW with its own commit: offered in the very next cycle with its rs0.
    begin
      int waited;
      drive_idle();
      issue_valid = 1'b1; issue_instr = FLW; issue_id = 4'd7; issue_rs0 = 32'hDEAD_BEEF;
      commit_valid = 1'b1; commit_id = 4'd7;
      #1;
      check("flw accept", 32'(issue_accept), 32'd1);
      @(posedge ck);
      #1;
      drive_idle();
      waited = 0;
      while (!fpu_valid && waited < 5) begin
        @(posedge ck); #1;
        waited++;
      end
      $display("seq flw: fpu_valid=%0b after %0d extra cycles fpu_id=%0d fpu_rs0=%h", fpu_valid, waited, fpu_id, fpu_rs0);
      check("flw latency", 32'(waited), 32'd0);
      check("flw fpu_instr", fpu_instr, FLW);
      check("flw fpu_rs0", fpu_rs0, 32'hDEAD_BEEF);
      @(negedge ck);
      fpu_ready = 1'b1;
      waited = 0;
      while (count != 3'd0 && waited < 5) begin
        @(posedge ck); #1;
        waited++;
      end
      $display("seq flw pop: count=%0d after %0d cycles", count, waited);
      check("flw pop cycles", 32'(waited), 32'd1);
      check("flw fpu_valid after pop", 32'(fpu_valid), 32'd0);
      @(negedge ck);
      drive_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t expected below 100000", $time);
    $fatal(1, "watchdog");
  end

endmodule
